// File: rtl/instr_fetch_seq_if.sv
// Bus bundle between the fetch sequencer (master) and the PC block / instruction memory side (slave).
// retired_count / stall_count exist only when INSTR_FETCH_SEQ_PERF_EN is defined.
interface instr_fetch_seq_if;
  logic [31:0] pc_addr;
  logic        finish;
  logic        exec_stall;
  logic [31:0] imem_readdata;
  logic        imem_waitrequest;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] instruction_word;
  logic        state;
  logic        active;
  logic        fault;
  logic [1:0]  dbg_state;
`ifdef INSTR_FETCH_SEQ_PERF_EN
  logic [31:0] retired_count;
  logic [31:0] stall_count;
`endif

  // Handshake: a read completes in the cycle imem_read=1 and imem_waitrequest=0;
  // while waitrequest is high the request (imem_read, imem_addr) is held stable.
  modport master (
    input  pc_addr, finish, exec_stall, imem_readdata, imem_waitrequest,
    output imem_read, imem_addr, instruction_word, state, active, fault, dbg_state
`ifdef INSTR_FETCH_SEQ_PERF_EN
    , output retired_count, stall_count
`endif
  );

  modport slave (
    output pc_addr, finish, exec_stall, imem_readdata, imem_waitrequest,
    input  imem_read, imem_addr, instruction_word, state, active, fault, dbg_state
`ifdef INSTR_FETCH_SEQ_PERF_EN
    , input retired_count, stall_count
`endif
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// Fetch/execute sequencer: issues instruction reads, latches the word, strobes PC advance.
// Optional performance counters enabled by defining INSTR_FETCH_SEQ_PERF_EN.
module instr_fetch_seq #(
  parameter int WAIT_TIMEOUT = 256,
  parameter int TO_W         = 9
) (
  input logic              clk,
  input logic              reset,
  instr_fetch_seq_if.master bus
);
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } fsm_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(WAIT_TIMEOUT - 1);

  fsm_t            cur;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     instr_q;
  logic            active_q;
  logic            fault_q;
  logic            misaligned;
  logic            fetch_req;

  assign misaligned = (bus.pc_addr[1:0] != 2'b00);
  assign fetch_req  = (cur == S_FETCH) && !bus.finish && !misaligned;

  // Request and advance strobe are decoded from the current state so they react in-cycle.
  assign bus.imem_addr        = bus.pc_addr;
  assign bus.imem_read        = fetch_req;
  assign bus.state            = (cur == S_EXEC) && !bus.exec_stall;
  assign bus.instruction_word = instr_q;
  assign bus.active           = active_q;
  assign bus.fault            = fault_q;
  assign bus.dbg_state        = cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= S_FETCH;
      to_cnt   <= '0;
      instr_q  <= '0;
      active_q <= 1'b1;
      fault_q  <= 1'b0;
    end else begin
      case (cur)
        S_FETCH: begin
          if (bus.finish) begin
            cur      <= S_HALT;
            active_q <= 1'b0;
            to_cnt   <= '0;
          end else if (misaligned) begin
            cur      <= S_FAULT;
            active_q <= 1'b0;
            fault_q  <= 1'b1;
            to_cnt   <= '0;
          end else if (!bus.imem_waitrequest) begin
            cur     <= S_EXEC;
            instr_q <= bus.imem_readdata;
            to_cnt  <= '0;
          end else if (to_cnt == TO_LAST) begin
            // This is the WAIT_TIMEOUT-th consecutive stalled cycle.
            cur      <= S_FAULT;
            active_q <= 1'b0;
            fault_q  <= 1'b1;
            to_cnt   <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          if (!bus.exec_stall) cur <= S_FETCH;
        end
        S_HALT:  cur <= S_HALT;
        default: cur <= S_FAULT;
      endcase
    end
  end

`ifdef INSTR_FETCH_SEQ_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;

  assign bus.retired_count = retired_q;
  assign bus.stall_count   = stall_q;

  // HALT and FAULT never satisfy either condition, so the counters freeze there.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (bus.state) retired_q <= retired_q + 32'd1;
      if (((cur == S_FETCH) && bus.imem_waitrequest) ||
          ((cur == S_EXEC) && bus.exec_stall))
        stall_q <= stall_q + 32'd1;
    end
  end
`endif
endmodule
